// File: rtl/uart_cmd_responder_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command responder.
// UART_CMD_CHECKSUM_EN adds the CHK / RESP_SUM states to the encoding.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] RSP_ACK    = 8'h4B;
    localparam logic [7:0] RSP_BADOP  = 8'h3F;
    localparam logic [7:0] RSP_BADSUM = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EXEC     = 3'd3,
        ST_RDWAIT   = 3'd4,
        ST_RESP     = 3'd5
`ifdef UART_CMD_CHECKSUM_EN
        ,
        ST_CHK      = 3'd6,
        ST_RESP_SUM = 3'd7
`endif
    } state_e;

    // Running frame checksum: XOR of every byte seen so far.
    function automatic logic [7:0] frame_sum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte stream, response handshake, register bus and status of the command responder.
// slave = responder view, master = host/system view.
interface uart_cmd_responder_if;
    logic       RX_VALID;
    logic [7:0] RX_DATA;
    logic       TX_READY;
    logic       TX_VALID;
    logic [7:0] TX_DATA;
    logic [7:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic       REG_RE;
    logic [7:0] REG_RDATA;
    logic       BUSY;
    logic       OVERRUN;

    modport slave (
        input  RX_VALID, RX_DATA, TX_READY, REG_RDATA,
        output TX_VALID, TX_DATA, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY, OVERRUN
    );

    modport master (
        output RX_VALID, RX_DATA, TX_READY, REG_RDATA,
        input  TX_VALID, TX_DATA, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY, OVERRUN
    );
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear.
// TIMEOUT of 0 keeps expired low permanently.
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic SCLK,
    input  logic RESET_N,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit          TIMER_ON_C = (TIMEOUT != 0);
    localparam logic [23:0] LIMIT_C    = TIMER_ON_C ? 24'(TIMEOUT - 1) : 24'd0;

    logic [23:0] cnt_r;

    // The cycle holding count LIMIT_C is the TIMEOUT-th cycle after the clearing byte.
    assign expired = TIMER_ON_C && enable && (cnt_r == LIMIT_C);

    // Count register: zero outside the waiting states and on every accepted byte.
    always_ff @(posedge SCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_r <= 24'd0;
        end else if (clear || !enable) begin
            cnt_r <= 24'd0;
        end else if (!expired) begin
            cnt_r <= cnt_r + 24'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Command-frame parser turning UART bytes into 8-bit register writes/reads with one response byte.
// UART_CMD_CHECKSUM_EN adds a trailing frame checksum and a response checksum byte.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input logic           SCLK,
    input logic           RESET_N,
    uart_cmd_responder_if.slave bus
);

    state_e     state_r, state_nxt_s;
    logic       tx_valid_r, tx_valid_nxt_s;
    logic [7:0] tx_data_r, tx_data_nxt_s;
    logic [7:0] addr_r, addr_nxt_s;
    logic [7:0] wdata_r, wdata_nxt_s;
    logic       we_r, we_nxt_s;
    logic       re_r, re_nxt_s;
    logic       busy_r;
    logic       overrun_r, overrun_nxt_s;
    logic       op_write_r, op_write_nxt_s;
    logic [7:0] sum_r, sum_nxt_s;
    logic       tmr_enable_s;
    logic       tmr_expired_s;

`ifdef UART_CMD_CHECKSUM_EN
    assign tmr_enable_s = (state_r == ST_ADDR) || (state_r == ST_DATA) || (state_r == ST_CHK);
`else
    assign tmr_enable_s = (state_r == ST_ADDR) || (state_r == ST_DATA);
`endif

    uart_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .SCLK    (SCLK),
        .RESET_N (RESET_N),
        .clear   (bus.RX_VALID),
        .enable  (tmr_enable_s),
        .expired (tmr_expired_s)
    );

    // Next-state and next-output decode; strobes are armed one state early so they register into EXEC.
    always_comb begin
        state_nxt_s    = state_r;
        tx_valid_nxt_s = tx_valid_r;
        tx_data_nxt_s  = tx_data_r;
        addr_nxt_s     = addr_r;
        wdata_nxt_s    = wdata_r;
        we_nxt_s       = 1'b0;
        re_nxt_s       = 1'b0;
        overrun_nxt_s  = overrun_r;
        op_write_nxt_s = op_write_r;
        sum_nxt_s      = sum_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.RX_VALID) begin
                    sum_nxt_s = bus.RX_DATA;
                    if ((bus.RX_DATA == OP_WRITE) || (bus.RX_DATA == OP_READ)) begin
                        op_write_nxt_s = (bus.RX_DATA == OP_WRITE);
                        state_nxt_s    = ST_ADDR;
                    end else begin
                        state_nxt_s    = ST_RESP;
                        tx_valid_nxt_s = 1'b1;
                        tx_data_nxt_s  = RSP_BADOP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.RX_VALID) begin
                    addr_nxt_s = bus.RX_DATA;
                    sum_nxt_s  = frame_sum(sum_r, bus.RX_DATA);
                    if (op_write_r) begin
                        state_nxt_s = ST_DATA;
                    end else begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_nxt_s = ST_CHK;
`else
                        state_nxt_s = ST_EXEC;
                        re_nxt_s    = 1'b1;
`endif
                    end
                end else if (tmr_expired_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.RX_VALID) begin
                    wdata_nxt_s = bus.RX_DATA;
                    sum_nxt_s   = frame_sum(sum_r, bus.RX_DATA);
`ifdef UART_CMD_CHECKSUM_EN
                    state_nxt_s = ST_CHK;
`else
                    state_nxt_s = ST_EXEC;
                    we_nxt_s    = 1'b1;
`endif
                end else if (tmr_expired_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (bus.RX_VALID) begin
                    if (bus.RX_DATA == sum_r) begin
                        state_nxt_s = ST_EXEC;
                        we_nxt_s    = op_write_r;
                        re_nxt_s    = !op_write_r;
                    end else begin
                        state_nxt_s    = ST_RESP;
                        tx_valid_nxt_s = 1'b1;
                        tx_data_nxt_s  = RSP_BADSUM;
                    end
                end else if (tmr_expired_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
`endif
            ST_EXEC: begin
                overrun_nxt_s = overrun_r | bus.RX_VALID;
                if (op_write_r) begin
                    state_nxt_s    = ST_RESP;
                    tx_valid_nxt_s = 1'b1;
                    tx_data_nxt_s  = RSP_ACK;
                end else begin
                    state_nxt_s = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                overrun_nxt_s  = overrun_r | bus.RX_VALID;
                state_nxt_s    = ST_RESP;
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = bus.REG_RDATA;
            end
            ST_RESP: begin
                overrun_nxt_s = overrun_r | bus.RX_VALID;
                if (tx_valid_r && bus.TX_READY) begin
`ifdef UART_CMD_CHECKSUM_EN
                    // Single-byte response, so its XOR checksum is the byte itself.
                    state_nxt_s   = ST_RESP_SUM;
                    tx_data_nxt_s = frame_sum(8'h00, tx_data_r);
`else
                    state_nxt_s    = ST_IDLE;
                    tx_valid_nxt_s = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_RESP_SUM: begin
                overrun_nxt_s = overrun_r | bus.RX_VALID;
                if (tx_valid_r && bus.TX_READY) begin
                    state_nxt_s    = ST_IDLE;
                    tx_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_RESP_SUM;
                end
            end
`endif
            default: begin
                state_nxt_s    = ST_IDLE;
                tx_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending response immediately.
    always_ff @(posedge SCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            addr_r     <= 8'h00;
            wdata_r    <= 8'h00;
            we_r       <= 1'b0;
            re_r       <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
            op_write_r <= 1'b0;
            sum_r      <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            addr_r     <= addr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            we_r       <= we_nxt_s;
            re_r       <= re_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            overrun_r  <= overrun_nxt_s;
            op_write_r <= op_write_nxt_s;
            sum_r      <= sum_nxt_s;
        end
    end

    assign bus.TX_VALID  = tx_valid_r;
    assign bus.TX_DATA   = tx_data_r;
    assign bus.REG_ADDR  = addr_r;
    assign bus.REG_WDATA = wdata_r;
    assign bus.REG_WE    = we_r;
    assign bus.REG_RE    = re_r;
    assign bus.BUSY      = busy_r;
    assign bus.OVERRUN   = overrun_r;

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder behind the `UART` block in the connection-block fabric. It consumes received bytes as short command frames and performs 8-bit register writes or reads on a simple local register bus. It returns one response byte per command through the UART transmit handshake. This gives the host a register access path over the serial link, for configuration and readback of connection-block state.

## Interface
Parameters:
- `TIMEOUT`, 1000000, inter-byte timeout in SCLK cycles. 0 disables the timeout. Must fit in 24 bits.

Ports:
- `SCLK`  in  1  system clock; all logic is on its rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `RX_VALID`  in  1  one-cycle pulse: `RX_DATA` holds a received byte; no backpressure
- `RX_DATA`  in  8  received byte
- `TX_READY`  in  1  transmitter can accept a byte
- `TX_VALID`  out  1  response byte available
- `TX_DATA`  out  8  response byte
- `REG_ADDR`  out  8  register address
- `REG_WDATA`  out  8  write data
- `REG_WE`  out  1  one-cycle write strobe
- `REG_RE`  out  1  one-cycle read strobe
- `REG_RDATA`  in  8  read data, valid exactly 1 cycle after `REG_RE`
- `BUSY`  out  1  high in any state other than IDLE
- `OVERRUN`  out  1  sticky; set when a byte is dropped; cleared only by reset

## Operation
- Command frames, one byte per `RX_VALID`:
  - write: `0x57`, addr, data
  - read: `0x52`, addr
- Responses:
  - write: `0x4B`
  - read: the register data byte
  - unknown opcode: `0x3F`, sent immediately with no further bytes consumed and no bus access
- State machine:
  - IDLE: on opcode byte, go to ADDR if the opcode is known; otherwise go to RESP with `0x3F`.
  - ADDR: latch `REG_ADDR`. Go to DATA for a write, or to EXEC for a read.
  - DATA: latch `REG_WDATA`, then go to EXEC.
  - EXEC: pulse `REG_WE` or `REG_RE` for one cycle. Go to RESP for a write, or to RDWAIT for a read.
  - RDWAIT: capture `REG_RDATA` into `TX_DATA`, then go to RESP.
  - RESP: hold `TX_VALID` with `TX_DATA` stable until a cycle with `TX_VALID & TX_READY`, then go to IDLE.
- Timeout:
  - In ADDR and DATA, a 24-bit counter counts cycles since the last accepted byte.
  - On reaching `TIMEOUT`, the block returns to IDLE silently, with no response and no bus access.
  - The counter clears on every accepted byte.
- Dropped bytes: an `RX_VALID` in EXEC, RDWAIT or RESP drops the byte and sets `OVERRUN`.
- Simultaneous `RX_VALID` and handshake completion in RESP: the byte is dropped and `OVERRUN` is set. The next frame starts only in IDLE.
- Reset mid-operation: returns immediately to IDLE, deasserts all outputs, and loses any pending response.
- Reset values: `TX_VALID`=0, `TX_DATA`=0x00, `REG_ADDR`=0x00, `REG_WDATA`=0x00, `REG_WE`=0, `REG_RE`=0, `BUSY`=0, `OVERRUN`=0.

## Timing
- All outputs are registered.
- Final command byte on `RX_VALID` in cycle t:
  - strobe (`REG_WE` or `REG_RE`) is high in cycle t+1
  - write: `TX_VALID` goes high in cycle t+2
  - read: `REG_RDATA` is sampled at the end of cycle t+2 and `TX_VALID` goes high in cycle t+3
- Unknown opcode in cycle t: `TX_VALID` goes high in cycle t+1.
- `TX_VALID` falls in the cycle after the handshake. `BUSY` falls in the same cycle.
- `TX_VALID` never depends combinationally on `TX_READY`.
- Strobes never last more than one cycle. `REG_WE` and `REG_RE` are never high together.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined:
  - Every frame carries a trailing checksum byte, equal to the XOR of all preceding frame bytes.
  - An extra state, CHK, sits before EXEC and is covered by the timeout.
  - Checksum mismatch: respond `0x21` with no bus access.
  - Every response is followed by a second byte, the XOR of the response bytes, using the same handshake.
  - Unknown opcode still responds immediately, with `0x3F` followed by its checksum `0x3F`.
- Undefined: no checksum bytes in either direction; the CHK state is absent.

## Structure
- Package `uart_cmd_pkg` holds:
  - opcode constants `OP_WRITE`=0x57 and `OP_READ`=0x52
  - response constants `RSP_ACK`=0x4B, `RSP_BADOP`=0x3F, `RSP_BADSUM`=0x21
  - the state enum
- One sub-module, `uart_cmd_timer`: the 24-bit timeout counter, with `clear`, `enable` and `expired` signals.
- Parser FSM, data registers and handshake logic stay in the top module.

## Test plan
- Write: bytes `57 10 A5` -> `REG_WE` for one cycle with addr 0x10 and data 0xA5, then one response `4B`.
- Read: `REG_RDATA`=0x3C and bytes `52 22` -> `REG_RE` with addr 0x22, then response `3C` at t+3.
- Bad opcode: byte `99` -> response `3F` at t+1, no bus strobe; next frame `52 01` is served normally.
- Timeout: `TIMEOUT`=100 and `57 10`, then 101 idle cycles, then `52 05` -> only the read executes and returns its data.
- Backpressure and overrun: `TX_READY` held low for 50 cycles during RESP while a byte arrives -> `TX_VALID` and `TX_DATA` stay stable; `OVERRUN`=1 after the byte; response completes when `TX_READY` rises.
- Async reset asserted in RDWAIT -> all outputs reach their reset values without a clock edge; `57 00 01` after release is served normally.
